// File: rtl/serial_buffer_pkg.sv
// Shared types and constants for the serial in/out buffers.
// State encoding, default geometry and a constant-safe clog2 helper.
package serial_buffer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 16;

  // Never returns less than 1 so it can size a vector for any value.
  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_gap_timer.sv
// Idle-cycle counter between accepted bits; o_expire is high on the cycle whose
// idle edge would be the TIMEOUT-th one. No backpressure; saturates at TIMEOUT.
module serial_gap_timer
  import serial_buffer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int TW = clog2(TIMEOUT + 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != TW'(TIMEOUT))) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_expire = (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/serial_in_buffer.sv
// MSB-first serial-to-parallel word collector; word is valid the cycle after its last bit.
// Held word waits for ready_in; a word completing while the previous is still held is dropped (overrun).
module serial_in_buffer
  import serial_buffer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             bit_in,
  input  logic             bit_valid_in,
  input  logic             start_in,
  output logic [WIDTH-1:0] vect_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy_out,
  output logic             frame_err_out,
  output logic             overrun_out,
  input  logic             clr_overrun_in
);

  localparam int CW = clog2(WIDTH + 1);
  // Only WIDTH-1 bits are ever held; the last bit goes straight to the output.
  localparam int SW = (WIDTH > 1) ? WIDTH - 1 : 1;

  state_t           r_state;
  logic [SW-1:0]    r_sreg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_vect;
  logic             r_valid;
  logic             r_busy;
  logic             r_frame_err;
  logic             r_overrun;

  state_t           w_state_nxt;
  logic [SW-1:0]    w_sreg_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_complete;
  logic             w_abort;
  logic             w_drop;
  logic             w_tmr_clr;
  logic             w_tmr_inc;
  logic             w_expire;

  if (WIDTH > 1) begin : g_shift
    assign w_shift = {r_sreg, bit_in};
  end else begin : g_shift1
    assign w_shift = bit_in;
  end

  assign w_word    = start_in ? WIDTH'(bit_in) : w_shift;
  assign w_cnt_inc = start_in ? CW'(1) : r_cnt + CW'(1);

  if (TIMEOUT > 0) begin : g_timer
    serial_gap_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_gap_timer (
      .i_clk   (clk_in),
      .i_rst_n (rst_in),
      .i_clr   (w_tmr_clr),
      .i_inc   (w_tmr_inc),
      .o_expire(w_expire)
    );
  end else begin : g_no_timer
    assign w_expire = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_tmr_clr   = 1'b1;
    w_tmr_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bit_valid_in && start_in) begin
          w_sreg_nxt = w_word[SW-1:0];
          if (WIDTH == 1) begin
            w_complete = 1'b1;
          end else begin
            w_cnt_nxt   = CW'(1);
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (bit_valid_in) begin
          w_sreg_nxt = w_word[SW-1:0];
          if (w_cnt_inc == CW'(WIDTH)) begin
            w_complete  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else if (w_expire) begin
          w_abort     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_clr = 1'b0;
          w_tmr_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_drop = w_complete && r_valid && !ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_vect      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= (w_state_nxt == ST_SHIFT);
      r_frame_err <= w_abort;
      // A drain and a completion on the same edge hand over without a bubble.
      if (w_complete && !w_drop) begin
        r_vect  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && ready_in) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun_in) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign vect_out      = r_vect;
  assign valid_out     = r_valid;
  assign busy_out      = r_busy;
  assign frame_err_out = r_frame_err;
  assign overrun_out   = r_overrun;

endmodule

// File: tb/tb_serial_in_buffer.sv
// Directed bench for serial_in_buffer with a queue scoreboard of expected words.
module tb_serial_in_buffer;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid_in = 1'b0;
  logic       start_in = 1'b0;
  logic [7:0] vect_out;
  logic       valid_out;
  logic       ready_in = 1'b1;
  logic       busy_out;
  logic       frame_err_out;
  logic       overrun_out;
  logic       clr_overrun_in = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         n_pass = 0;
  int         n_total = 0;
  int         err_cnt = 0;

  serial_in_buffer #(
    .WIDTH  (8),
    .TIMEOUT(16)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .bit_in        (bit_in),
    .bit_valid_in  (bit_valid_in),
    .start_in      (start_in),
    .vect_out      (vect_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .busy_out      (busy_out),
    .frame_err_out (frame_err_out),
    .overrun_out   (overrun_out),
    .clr_overrun_in(clr_overrun_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // One clock: observe at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk_in);
    if (frame_err_out) err_cnt++;
    if (valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {31'd0, valid_out}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("word", {24'd0, vect_out}, {24'd0, mon_exp});
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    bit_in       = b;
    start_in     = st;
    bit_valid_in = 1'b1;
    tick();
    bit_valid_in = 1'b0;
    start_in     = 1'b0;
    bit_in       = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], i == 7);
      if (i > 0) repeat (gap) tick();
    end
  endtask

  initial begin
    logic [7:0] pat;
    #2;
    chk("rst_vect", {24'd0, vect_out}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err_out}, 32'd0);
    chk("rst_ovr", {31'd0, overrun_out}, 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    tick();

    // Single word, exact latency and one-cycle valid with ready held high.
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 0);
    chk("a5_valid", {31'd0, valid_out}, 32'd1);
    chk("a5_vect", {24'd0, vect_out}, 32'h0000_00A5);
    chk("a5_busy", {31'd0, busy_out}, 32'd0);
    tick();
    chk("a5_valid_drop", {31'd0, valid_out}, 32'd0);

    // Gaps shorter than the timeout.
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 5);
    tick();
    chk("gap_no_err", err_cnt, 32'd0);

    // Gap timeout after a 3-bit partial frame.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("to_busy", {31'd0, busy_out}, 32'd1);
    repeat (15) tick();
    chk("to_busy_15", {31'd0, busy_out}, 32'd1);
    chk("to_no_err_15", err_cnt, 32'd0);
    tick();
    chk("to_ferr", {31'd0, frame_err_out}, 32'd1);
    chk("to_busy_0", {31'd0, busy_out}, 32'd0);
    chk("to_valid", {31'd0, valid_out}, 32'd0);
    tick();
    chk("to_ferr_pulse", {31'd0, frame_err_out}, 32'd0);
    chk("to_err_once", err_cnt, 32'd1);
    exp_q.push_back(8'hFF);
    send_word(8'hFF, 0);
    tick();

    // Restart mid-frame discards the partial word silently.
    send_bit(1'b1, 1'b1);
    repeat (3) send_bit(1'b1, 1'b0);
    exp_q.push_back(8'h81);
    send_word(8'h81, 0);
    tick();
    chk("rs_err", err_cnt, 32'd1);
    chk("rs_ovr", {31'd0, overrun_out}, 32'd0);

    // Overrun: second word dropped while the first is held.
    ready_in = 1'b0;
    exp_q.push_back(8'h11);
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    chk("ov_vect", {24'd0, vect_out}, 32'h0000_0011);
    chk("ov_valid", {31'd0, valid_out}, 32'd1);
    chk("ov_flag", {31'd0, overrun_out}, 32'd1);
    ready_in = 1'b1;
    tick();
    chk("ov_drained", {31'd0, valid_out}, 32'd0);
    chk("ov_sticky", {31'd0, overrun_out}, 32'd1);
    clr_overrun_in = 1'b1;
    tick();
    clr_overrun_in = 1'b0;
    chk("ov_clear", {31'd0, overrun_out}, 32'd0);

    // Drain and completion on the same edge.
    ready_in = 1'b0;
    exp_q.push_back(8'h33);
    send_word(8'h33, 0);
    pat = 8'h44;
    for (int i = 7; i >= 1; i--) send_bit(pat[i], i == 7);
    ready_in = 1'b1;
    exp_q.push_back(8'h44);
    send_bit(pat[0], 1'b0);
    chk("se_valid", {31'd0, valid_out}, 32'd1);
    chk("se_vect", {24'd0, vect_out}, 32'h0000_0044);
    chk("se_ovr", {31'd0, overrun_out}, 32'd0);
    tick();

    // Asynchronous reset in the middle of a frame with a word held.
    ready_in = 1'b0;
    send_word(8'h99, 0);
    pat = 8'hC3;
    for (int i = 7; i >= 3; i--) send_bit(pat[i], i == 7);
    chk("mr_busy", {31'd0, busy_out}, 32'd1);
    rst_in = 1'b0;
    #1;
    chk("mr_vect", {24'd0, vect_out}, 32'd0);
    chk("mr_valid", {31'd0, valid_out}, 32'd0);
    chk("mr_busy0", {31'd0, busy_out}, 32'd0);
    chk("mr_ovr", {31'd0, overrun_out}, 32'd0);
    chk("mr_ferr", {31'd0, frame_err_out}, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in   = 1'b1;
    ready_in = 1'b1;
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 0);
    chk("mr_5a", {24'd0, vect_out}, 32'h0000_005A);
    repeat (3) tick();

    chk("q_empty", exp_q.size(), 32'd0);
    chk("err_total", err_cnt, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
